// File: rtl/fma_wb_batch_if.sv
// Bus bundle for fma_wb_batch: Wishbone slave signals plus the operand/result
// handshake toward the external FMA core. Signal names keep the original
// port names so existing hookups map one-to-one.
interface fma_wb_batch_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             wbs_stb_i;
    logic             wbs_cyc_i;
    logic             wbs_we_i;
    logic [3:0]       wbs_sel_i;
    logic [31:0]      wbs_adr_i;
    logic [31:0]      wbs_dat_i;
    logic             wbs_ack_o;
    logic [31:0]      wbs_dat_o;

    logic             core_valid_o;
    logic             core_ready_i;
    logic [WIDTH-1:0] core_a_o;
    logic [WIDTH-1:0] core_b_o;
    logic [WIDTH-1:0] core_c_o;
    logic             core_res_valid_i;
    logic [WIDTH-1:0] core_res_i;
    logic [9:0]       core_flags_i;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output core_valid_o, core_a_o, core_b_o, core_c_o,
        input  core_ready_i, core_res_valid_i, core_res_i, core_flags_i
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  core_valid_o, core_a_o, core_b_o, core_c_o,
        output core_ready_i, core_res_valid_i, core_res_i, core_flags_i
    );
endinterface

// File: rtl/fma_wb_batch.sv
// Wishbone batch front-end for a pipelined bfloat16 FMA core.
// Operand triples are queued in a command FIFO and issued over valid/ready;
// results are collected in issue order into a result FIFO read over the bus.
// Optional macro FMA_WB_IRQ_EN enables the IRQ_EN register and irq_o.
module fma_wb_batch #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    fma_wb_batch_if.slave bus,
    output logic          irq_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [7:0] OFF_OPAB  = 8'h00;
    localparam logic [7:0] OFF_PUSH  = 8'h04;
    localparam logic [7:0] OFF_RES   = 8'h08;
    localparam logic [7:0] OFF_STAT  = 8'h0C;
    localparam logic [7:0] OFF_IRQEN = 8'h10;

    // Bus request capture
    logic        sel_w;
    logic        ack_q, req_wr_q, req_rd_q;
    logic [7:0]  req_off_q;
    logic [31:0] req_dat_q;

    // Decoded ack-cycle actions
    logic wr_opab, push_req, rd_res, wr_stat;
    logic cmd_push, ovf_set, res_pop, unf_set, issue, res_push;

    // Command FIFO
    logic [WIDTH-1:0] cmd_a_q [DEPTH];
    logic [WIDTH-1:0] cmd_b_q [DEPTH];
    logic [WIDTH-1:0] cmd_c_q [DEPTH];
    logic [PW-1:0]    cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CW-1:0]    cmd_cnt_q, cmd_cnt_d;

    // Result FIFO
    logic [WIDTH-1:0] res_dat_q [DEPTH];
    logic [9:0]       res_flg_q [DEPTH];
    logic [PW-1:0]    res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CW-1:0]    res_cnt_q, res_cnt_d;

    // Control/status state
    logic [CW-1:0]    out_q, out_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [31:0]      rdata;

    assign sel_w = bus.wbs_stb_i & bus.wbs_cyc_i & ~ack_q &
                   (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);

    // Register the access; side effects then happen during the ack cycle
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q     <= 1'b0;
            req_wr_q  <= 1'b0;
            req_rd_q  <= 1'b0;
            req_off_q <= '0;
            req_dat_q <= '0;
        end else begin
            ack_q <= sel_w;
            if (sel_w) begin
                req_wr_q  <= bus.wbs_we_i & (&bus.wbs_sel_i);
                req_rd_q  <= ~bus.wbs_we_i;
                req_off_q <= bus.wbs_adr_i[7:0];
                req_dat_q <= bus.wbs_dat_i;
            end
        end
    end

    // Issue handshake toward the core; result room is reserved at issue time
    always_comb begin
        bus.core_valid_o = (cmd_cnt_q != '0) &&
                           (({1'b0, res_cnt_q} + {1'b0, out_q}) < {1'b0, FULL});
        bus.core_a_o     = cmd_a_q[cmd_rd_q];
        bus.core_b_o     = cmd_b_q[cmd_rd_q];
        bus.core_c_o     = cmd_c_q[cmd_rd_q];
    end

    // Decode ack-cycle actions and FIFO events
    always_comb begin
        wr_opab  = ack_q & req_wr_q & (req_off_q == OFF_OPAB);
        push_req = ack_q & req_wr_q & (req_off_q == OFF_PUSH);
        rd_res   = ack_q & req_rd_q & (req_off_q == OFF_RES);
        wr_stat  = ack_q & req_wr_q & (req_off_q == OFF_STAT);
        cmd_push = push_req & (cmd_cnt_q != FULL);
        ovf_set  = push_req & (cmd_cnt_q == FULL);
        res_pop  = rd_res & (res_cnt_q != '0);
        unf_set  = rd_res & (res_cnt_q == '0);
        issue    = bus.core_valid_o & bus.core_ready_i;
        res_push = bus.core_res_valid_i & (out_q != '0);
    end

    // Next-state for pointers, counts, flags and the holding register
    always_comb begin
        cmd_wr_d  = cmd_wr_q + PW'(cmd_push);
        cmd_rd_d  = cmd_rd_q + PW'(issue);
        cmd_cnt_d = cmd_cnt_q + CW'(cmd_push) - CW'(issue);
        res_wr_d  = res_wr_q + PW'(res_push);
        res_rd_d  = res_rd_q + PW'(res_pop);
        res_cnt_d = res_cnt_q + CW'(res_push) - CW'(res_pop);
        out_d     = out_q + CW'(issue) - CW'(res_push);
        ovf_d     = (ovf_q | ovf_set) & ~(wr_stat & req_dat_q[24]);
        unf_d     = (unf_q | unf_set) & ~(wr_stat & req_dat_q[25]);
        opa_d     = opa_q;
        opb_d     = opb_q;
        if (wr_opab) begin
            opa_d = req_dat_q[WIDTH-1:0];
            opb_d = req_dat_q[16 +: WIDTH];
        end
    end

    // Control/status state registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
        end else begin
            cmd_wr_q  <= cmd_wr_d;
            cmd_rd_q  <= cmd_rd_d;
            cmd_cnt_q <= cmd_cnt_d;
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            res_cnt_q <= res_cnt_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
        end
    end

    // FIFO storage writes; contents are don't-care while empty
    always_ff @(posedge wb_clk_i) begin
        if (cmd_push) begin
            cmd_a_q[cmd_wr_q] <= opa_q;
            cmd_b_q[cmd_wr_q] <= opb_q;
            cmd_c_q[cmd_wr_q] <= req_dat_q[WIDTH-1:0];
        end
        if (res_push) begin
            res_dat_q[res_wr_q] <= bus.core_res_i;
            res_flg_q[res_wr_q] <= bus.core_flags_i;
        end
    end

`ifdef FMA_WB_IRQ_EN
    logic wr_irqen, irq_en_q, irq_en_d, irq_q, irq_d;

    // Interrupt enable and registered level interrupt
    always_comb begin
        wr_irqen = ack_q & req_wr_q & (req_off_q == OFF_IRQEN);
        irq_en_d = wr_irqen ? req_dat_q[0] : irq_en_q;
        irq_d    = irq_en_q & (res_cnt_q != '0);
    end

    // Interrupt state registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // Read mux; data is driven only in the ack cycle
    always_comb begin
        rdata = '0;
        if (ack_q && req_rd_q) begin
            case (req_off_q)
                OFF_OPAB: begin
                    rdata[WIDTH-1:0]  = opa_q;
                    rdata[16 +: WIDTH] = opb_q;
                end
                OFF_RES: begin
                    if (res_cnt_q != '0) begin
                        rdata[31:22]      = res_flg_q[res_rd_q];
                        rdata[WIDTH-1:0]  = res_dat_q[res_rd_q];
                    end
                end
                OFF_STAT: begin
                    rdata[CW-1:0]    = cmd_cnt_q;
                    rdata[8 +: CW]   = res_cnt_q;
                    rdata[16 +: CW]  = out_q;
                    rdata[24]        = ovf_q;
                    rdata[25]        = unf_q;
                    rdata[26]        = (cmd_cnt_q != '0) || (out_q != '0);
                end
`ifdef FMA_WB_IRQ_EN
                OFF_IRQEN: rdata[0] = irq_en_q;
`endif
                default: rdata = '0;
            endcase
        end
        bus.wbs_ack_o = ack_q;
        bus.wbs_dat_o = rdata;
    end
endmodule

// File: tb/tb_fma_wb_batch.sv
// Directed bench for fma_wb_batch (DEPTH=4, WIDTH=16) with a latency-3 core model.
module tb_fma_wb_batch;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_issue = 0;
    int   n_coinc = 0;

    fma_wb_batch_if #(.WIDTH(16)) bus ();

    fma_wb_batch #(.WIDTH(16), .DEPTH(4), .BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in the ack cycle (1 time unit after the ack edge)
    task automatic wb_cycle(input logic we, input logic [7:0] off, input logic [31:0] wd,
                            input logic [3:0] sel, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        bus.wbs_adr_i = BASE | {24'h0, off};
        bus.wbs_dat_i = wd;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            got = bus.wbs_ack_o;
        end
        rd = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        if (!got) check("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wb_wr(input logic [7:0] off, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_cycle(1'b1, off, wd, 4'hF, dummy);
    endtask

    task automatic wb_rd(input logic [7:0] off, output logic [31:0] rd);
        wb_cycle(1'b0, off, 32'h0, 4'hF, rd);
    endtask

    // Core model: 3-cycle latency, 1.0*2.0+1.0 -> 3.0, otherwise a+c with flags = b[9:0]
    logic        pv [4];
    logic [15:0] pr [4];
    logic [9:0]  pf [4];
    initial begin
        logic fire;
        bus.core_res_valid_i = 1'b0;
        bus.core_res_i       = '0;
        bus.core_flags_i     = '0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0; pr[i] = '0; pf[i] = '0;
        end
        forever begin
            @(negedge clk);
            fire = bus.core_valid_o & bus.core_ready_i;
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1]; pr[i] = pr[i-1]; pf[i] = pf[i-1];
            end
            pv[0] = fire;
            if (bus.core_a_o == 16'h3F80 && bus.core_b_o == 16'h4000 && bus.core_c_o == 16'h3F80) begin
                pr[0] = 16'h4040; pf[0] = '0;
            end else begin
                pr[0] = bus.core_a_o + bus.core_c_o; pf[0] = bus.core_b_o[9:0];
            end
            bus.core_res_valid_i = pv[3];
            bus.core_res_i       = pr[3];
            bus.core_flags_i     = pf[3];
            if (fire) n_issue++;
            if (fire && pv[3]) n_coinc++;
        end
    end

    initial begin
        logic [31:0] d;
        int          base_cnt;
        logic [31:0] exp_res [5];
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
        bus.core_ready_i = 1'b0;

        // Reset state
        idle(3);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        check("rst_valid", 32'(bus.core_valid_o), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        idle(1);
        wb_rd(8'h0C, d); check("rst_status", d, 32'h0);
        wb_rd(8'h00, d); check("rst_opab", d, 32'h0);

        // Single op: 1.0 * 2.0 + 1.0
        bus.core_ready_i = 1'b1;
        wb_wr(8'h00, 32'h4000_3F80);
        wb_rd(8'h00, d); check("opab_rb", d, 32'h4000_3F80);
        wb_wr(8'h04, 32'h0000_3F80);
        check("valid_in_ack", 32'(bus.core_valid_o), 32'd0);
        idle(1);
        check("push_to_valid", 32'(bus.core_valid_o), 32'd1);
        check("core_a", 32'(bus.core_a_o), 32'h3F80);
        check("core_b", 32'(bus.core_b_o), 32'h4000);
        check("core_c", 32'(bus.core_c_o), 32'h3F80);
        for (int i = 0; i < 20; i++) begin
            wb_rd(8'h0C, d);
            if (!d[26]) break;
        end
        check("single_done", d, 32'h0000_0100);
        wb_rd(8'h08, d); check("single_res", d, 32'h0000_4040);
        wb_rd(8'h0C, d); check("single_empty", d, 32'h0);

        // Fill with core stalled
        bus.core_ready_i = 1'b0;
        wb_wr(8'h00, 32'h0002_0001);
        for (int i = 0; i < 5; i++) wb_wr(8'h04, 32'h10 + 32'(i));
        wb_rd(8'h0C, d); check("fill_status", d, 32'h0500_0004);
        idle(3);
        check("stall_valid", 32'(bus.core_valid_o), 32'd1);
        check("stall_head", 32'(bus.core_c_o), 32'h10);
        wb_wr(8'h0C, 32'h0100_0000);
        wb_rd(8'h0C, d); check("ovf_clear", d, 32'h0400_0004);

        // Drain into result FIFO; last issue coincides with first result
        base_cnt = n_coinc;
        bus.core_ready_i = 1'b1;
        idle(12);
        wb_rd(8'h0C, d); check("res_full", d, 32'h0000_0400);
        check("coincident", 32'(n_coinc != base_cnt), 32'd1);

        // Back-pressure with results unread
        wb_wr(8'h04, 32'h15);
        wb_wr(8'h04, 32'h16);
        idle(4);
        check("bp_valid", 32'(bus.core_valid_o), 32'd0);
        wb_rd(8'h0C, d); check("bp_status", d, 32'h0400_0402);
        base_cnt = n_issue;
        wb_rd(8'h08, d); check("res0", d, 32'h0080_0011);
        idle(10);
        check("one_issue", 32'(n_issue - base_cnt), 32'd1);
        wb_rd(8'h0C, d); check("bp_status2", d, 32'h0400_0401);
        exp_res[0] = 32'h0080_0012; exp_res[1] = 32'h0080_0013; exp_res[2] = 32'h0080_0014;
        exp_res[3] = 32'h0080_0016; exp_res[4] = 32'h0080_0017;
        for (int i = 0; i < 5; i++) begin
            wb_rd(8'h08, d);
            check($sformatf("res%0d", i + 1), d, exp_res[i]);
            idle(10);
        end
        wb_rd(8'h0C, d); check("drained", d, 32'h0);

        // Underflow
        wb_rd(8'h08, d); check("unf_data", d, 32'h0);
        wb_rd(8'h0C, d); check("unf_status", d, 32'h0200_0000);
        wb_wr(8'h0C, 32'h0200_0000);
        wb_rd(8'h0C, d); check("unf_clear", d, 32'h0);

        // Unmapped offset, partial byte select, foreign address
        wb_wr(8'h20, 32'hFFFF_FFFF);
        wb_rd(8'h20, d); check("unmapped_rd", d, 32'h0);
        wb_cycle(1'b1, 8'h00, 32'h1234_5678, 4'h7, d);
        wb_rd(8'h00, d); check("partial_sel", d, 32'h0002_0001);
        bus.wbs_adr_i = BASE + 32'h100; bus.wbs_we_i = 1'b0;
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
        idle(3);
        check("miss_no_ack", 32'(bus.wbs_ack_o), 32'd0);
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
        idle(1);

        // Interrupt
        wb_wr(8'h10, 32'h1);
`ifdef FMA_WB_IRQ_EN
        wb_rd(8'h10, d); check("irqen_rb", d, 32'h1);
        wb_wr(8'h04, 32'h20);
        idle(10);
        check("irq_rise", 32'(irq), 32'd1);
        wb_rd(8'h08, d); check("irq_res", d, 32'h0080_0021);
        idle(1);
        check("irq_hold", 32'(irq), 32'd1);
        idle(1);
        check("irq_fall", 32'(irq), 32'd0);
`else
        wb_rd(8'h10, d); check("irqen_rb", d, 32'h0);
        wb_wr(8'h04, 32'h20);
        idle(10);
        check("irq_tied", 32'(irq), 32'd0);
        wb_rd(8'h08, d); check("irq_res", d, 32'h0080_0021);
`endif

        // Reset mid-batch
        bus.core_ready_i = 1'b0;
        wb_wr(8'h04, 32'h30);
        wb_wr(8'h04, 32'h31);
        wb_wr(8'h04, 32'h32);
        idle(1);
        bus.core_ready_i = 1'b1;
        idle(5);
`ifdef FMA_WB_IRQ_EN
        check("irq_pre_rst", 32'(irq), 32'd1);
`endif
        rst_n = 1'b0;
        idle(2);
        check("mid_rst_valid", 32'(bus.core_valid_o), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        idle(8);
        wb_rd(8'h0C, d); check("post_rst_status", d, 32'h0);
        check("post_rst_irq", 32'(irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fma_wb_batch.md
# fma_wb_batch

Parametrised Wishbone batch front-end for the bfloat16 FMA datapath. It replaces the single-shot register access with operand and result FIFOs, so the management core can queue up to DEPTH fused multiply-adds and collect the results later. It sits between the Wishbone slave port of the user project and an external pipelined FMA core, and issues operand triples over a valid/ready handshake. Results are collected out of order relative to bus traffic but strictly in issue order.

## Interface
Parameters:
- WIDTH, 16, operand/result width (8..16)
- DEPTH, 4, entries in each of the command and result FIFOs (power of two, 2..16)
- BASE_ADDR, 32'h3000_0000, Wishbone base; bits [7:0] must be zero

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset, synchronous, active-low
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe/cycle/write
- wbs_sel_i  in  4  byte selects; a write takes effect only if all four are set
- wbs_adr_i, wbs_dat_i  in  32  address / write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- core_valid_o  out  1  operand triple valid
- core_ready_i  in  1  core accepts a triple
- core_a_o, core_b_o, core_c_o  out  WIDTH  operands; the core computes a*b+c
- core_res_valid_i  in  1  result strobe, one cycle per result, in issue order
- core_res_i  in  WIDTH  result
- core_flags_i  in  10  exception flags
- irq_o  out  1  interrupt

## Operation
Decode: an access is selected when stb & cyc and wbs_adr_i[31:8] == BASE_ADDR[31:8]. The offset is wbs_adr_i[7:0].

Register map:
- 0x00 OPAB, R/W: [WIDTH-1:0] = a, [16+WIDTH-1:16] = b; holding register.
- 0x04 PUSH, W: [WIDTH-1:0] = c. Enqueues {a,b,c}. If the command FIFO is full, the write is dropped and STATUS.ovf is set.
- 0x08 RES, R: dequeues {flags[9:0] at [31:22], zero pad, result at [WIDTH-1:0]}. If the result FIFO is empty, returns 0 and sets STATUS.unf.
- 0x0C STATUS, R: [4:0] cmd count, [12:8] result count, [20:16] outstanding, [24] ovf, [25] unf, [26] busy (cmd count or outstanding nonzero).
- 0x0C STATUS, W: write-1-to-clear of bits 24 and 25.
- 0x10 IRQ_EN, R/W: bit 0.
- Other offsets: reads return 0, writes are ignored; ack is still returned.

Issue:
- core_valid_o = cmd non-empty && (result count + outstanding) < DEPTH. This guarantees the result FIFO can never overflow.
- A handshake (valid & ready) pops the command FIFO and increments outstanding.
- core_res_valid_i pushes the result FIFO and decrements outstanding.
- When an issue and a result occur in the same cycle, outstanding is unchanged.
- A result strobe while outstanding is 0 is ignored.

FIFO boundaries:
- Push and pop in the same cycle on a non-empty FIFO: count is unchanged.
- On an empty FIFO only the push takes effect.
- Pointers wrap modulo DEPTH; counts range 0..DEPTH.

## Timing
- Ack: registered, asserted exactly one cycle after a selected cycle, then low for at least one cycle. No back-to-back acks, so each access costs 2 cycles.
- Register side effects (push, pop, clear) are committed in the ack cycle.
- Read data is valid in the ack cycle; wbs_dat_o is 0 when ack is low.
- Latency from a PUSH ack to core_valid_o: 1 cycle when issue is permitted.
- core_a/b/c_o hold the FIFO head, stable while valid is high and ready is low.
- Reset (wb_rst_ni low at a clock edge):
  - all FIFOs empty; outstanding, ovf, unf, IRQ_EN, OPAB = 0
  - wbs_ack_o, wbs_dat_o, core_valid_o, irq_o = 0
- Reset mid-operation discards queued and in-flight work. Results arriving in the first cycle after reset are ignored, because outstanding is 0.

## Configuration
- FMA_WB_IRQ_EN defined: irq_o is a registered output, equal to IRQ_EN[0] & (result count != 0), updated 1 cycle after the count changes.
- FMA_WB_IRQ_EN undefined: irq_o is tied 0, IRQ_EN reads 0 and writes are ignored.

## Test plan
- Single op: OPAB = 0x4000_3F80 (b = 2.0, a = 1.0), PUSH c = 0x3F80, core model of latency 3 -> STATUS busy clears; RES reads 0x0000_4040 (3.0) with flags 0.
- Fill: DEPTH=4, core_ready_i held 0, 5 PUSHes -> cmd count 4, ovf = 1; a STATUS write of 1<<24 clears ovf.
- Back-pressure: 4 results pending unread -> core_valid_o stays 0 even with cmd non-empty; one RES read -> exactly one further issue.
- Underflow: RES read on empty -> data 0, unf = 1, counts unchanged.
- Simultaneous events: issue and result strobe in the same cycle -> outstanding unchanged; order of 6 queued results matches push order across pointer wrap.
- IRQ (FMA_WB_IRQ_EN): IRQ_EN = 1, complete one op -> irq_o rises; read RES -> irq_o falls 1 cycle later; assert reset mid-batch -> all counts 0 and irq_o = 0.
